// File: rtl/dcache_pkg.sv
// Shared geometry and FSM state type for the direct-mapped write-back data cache.
//   LINES     : number of cache lines
//   LINE_BITS : bits per line (four 32-bit words)
//   TAG_W     : tag width taken from addr[31:9]
//   INDEX_W   : line index width taken from addr[8:4]
//   OFFSET_W  : word offset width taken from addr[3:2]
package dcache_pkg;
    localparam int LINES     = 32;
    localparam int LINE_BITS = 128;
    localparam int TAG_W     = 23;
    localparam int INDEX_W   = 5;
    localparam int OFFSET_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WRITEBACK   = 2'd1,
        S_ALLOCATE    = 2'd2,
        S_REFILL_WAIT = 2'd3
    } state_e;
endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and backing-memory-side signals of the data cache.
// Signal names are seen from the cache: *_i are driven by the environment,
// *_o by the cache.
//   req_i/wen_i/addr_i/wdata_i : CPU access request, store flag, byte address, store data
//   rdata_o/stall_o            : load data, pipeline freeze
//   mem_req_o/mem_wen_o        : memory request, 1=write-back 0=line fetch
//   mem_addr_o/mem_wdata_o     : line-aligned address, victim line
//   mem_rdata_i/mem_ack_i      : fetched line, one-cycle completion pulse
// modport master : CPU + memory environment
// modport slave  : cache controller
interface dcache_controller_if;
    import dcache_pkg::*;

    logic                 req_i;
    logic                 wen_i;
    logic [31:0]          addr_i;
    logic [31:0]          wdata_i;
    logic [31:0]          rdata_o;
    logic                 stall_o;
    logic                 mem_req_o;
    logic                 mem_wen_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_wdata_o;
    logic [LINE_BITS-1:0] mem_rdata_i;
    logic                 mem_ack_i;

    modport master (
        output req_i, wen_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
        input  rdata_o, stall_o, mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  req_i, wen_i, addr_i, wdata_i, mem_rdata_i, mem_ack_i,
        output rdata_o, stall_o, mem_req_o, mem_wen_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data arrays of the cache. Combinational read of the
// indexed line, synchronous write. Only valid/dirty are reset; tag and data
// contents are meaningless while the line is invalid.
//   i_index              : line being read/written
//   i_fill_we            : write whole line + tag, mark valid and clean
//   i_fill_tag/line      : refill tag and data
//   i_word_we            : write one word, mark dirty
//   i_word_off/data      : word offset and store data
//   o_tag/valid/dirty    : indexed line metadata
//   o_line               : indexed line data
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INDEX_W-1:0]   i_index,
    input  logic                 i_fill_we,
    input  logic [TAG_W-1:0]     i_fill_tag,
    input  logic [LINE_BITS-1:0] i_fill_line,
    input  logic                 i_word_we,
    input  logic [OFFSET_W-1:0]  i_word_off,
    input  logic [31:0]          i_word_data,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [LINE_BITS-1:0] o_line
);
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];
    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_line;
        end else if (i_word_we) begin
            r_data[i_index][{i_word_off, 5'd0} +: 32] <= i_word_data;
        end
    end

    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_line  = r_data[i_index];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
//   clk_i : clock, rst_i : asynchronous active-high reset
//   bus   : CPU and backing-memory signals (dcache_controller_if.slave)
//
// state         | meaning
// --------------+-----------------------------------------------------------
// S_IDLE        | serve hits; a miss picks WRITEBACK (dirty victim) or ALLOCATE
// S_WRITEBACK   | victim line on the bus as a write until acked
// S_ALLOCATE    | line fetch on the bus until acked; line filled on the ack
// S_REFILL_WAIT | one settle cycle, then the request re-runs as a hit in IDLE
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    dcache_controller_if.slave bus
);
    state_e               r_state;
    state_e               w_state_next;
    logic                 r_ack_gap;
    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_index;
    logic [OFFSET_W-1:0]  w_off;
    logic [TAG_W-1:0]     w_line_tag;
    logic                 w_line_valid;
    logic                 w_line_dirty;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_hit;
    logic                 w_mem_req;
    logic                 w_ack;
    logic                 w_fill_we;
    logic                 w_word_we;
    logic                 w_unused_addr;

    assign w_tag         = bus.addr_i[31:9];
    assign w_index       = bus.addr_i[8:4];
    assign w_off         = bus.addr_i[3:2];
    assign w_unused_addr = ^bus.addr_i[1:0];
    assign w_hit         = w_line_valid && (w_line_tag == w_tag);

    // The cycle after an accepted ack keeps the request low, so the
    // write-back -> fetch hand-over shows a one-cycle gap on mem_req_o.
    assign w_mem_req = (r_state == S_WRITEBACK) ||
                       ((r_state == S_ALLOCATE) && !r_ack_gap);
    // An ack only counts while a request is actually outstanding.
    assign w_ack     = bus.mem_ack_i && w_mem_req;
    assign w_fill_we = (r_state == S_ALLOCATE) && w_ack;
    assign bus.mem_req_o = w_mem_req;

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_index     (w_index),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_line (bus.mem_rdata_i),
        .i_word_we   (w_word_we),
        .i_word_off  (w_off),
        .i_word_data (bus.wdata_i),
        .o_tag       (w_line_tag),
        .o_valid     (w_line_valid),
        .o_dirty     (w_line_dirty),
        .o_line      (w_line)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ack_gap <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ack_gap <= w_ack;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_i && !w_hit) begin
                    w_state_next = (w_line_valid && w_line_dirty) ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK:   if (w_ack) w_state_next = S_ALLOCATE;
            S_ALLOCATE:    if (w_ack) w_state_next = S_REFILL_WAIT;
            S_REFILL_WAIT: w_state_next = S_IDLE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.stall_o     = 1'b0;
        bus.rdata_o     = '0;
        bus.mem_wen_o   = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        w_word_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_i) begin
                    bus.stall_o = !w_hit;
                    if (w_hit && bus.wen_i) begin
                        w_word_we = 1'b1;
                    end else if (w_hit) begin
                        bus.rdata_o = w_line[{w_off, 5'd0} +: 32];
                    end
                end
            end
            S_WRITEBACK: begin
                bus.stall_o     = 1'b1;
                bus.mem_wen_o   = 1'b1;
                bus.mem_addr_o  = {w_line_tag, w_index, 4'b0000};
                bus.mem_wdata_o = w_line;
            end
            S_ALLOCATE: begin
                bus.stall_o    = 1'b1;
                bus.mem_addr_o = {bus.addr_i[31:4], 4'b0000};
            end
            S_REFILL_WAIT: bus.stall_o = 1'b1;
            default: bus.stall_o = 1'b0;
        endcase
        // The state register already clears asynchronously; these two depend
        // on req_i/hit as well, so they are forced quiet while reset is held.
        if (rst_i) begin
            bus.stall_o = 1'b0;
            bus.rdata_o = '0;
            w_word_we   = 1'b0;
        end
    end
endmodule
